// File: rtl/rv32i_types.sv
// Shared types and constants for the common-data-bus arbiter.
package rv32i_types;

  localparam int CDB_NUM_REQ = 3;
  localparam int CDB_NUM_CDB = 2;
  localparam int CDB_WIDTH   = 32;
  localparam int CDB_TAG_W   = 3;

  localparam logic [1:0] REQ_ACU = 2'd0;
  localparam logic [1:0] REQ_BR  = 2'd1;
  localparam logic [1:0] REQ_LSQ = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_WIDTH-1:0] data;
    logic [1:0]           src;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: grants up to NUM_CDB requesters,
// scanning from rr_ptr_i, and maps the k-th grant onto lane k.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int NUM_CDB = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [PTR_W-1:0]              rr_ptr_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_CDB-1:0]            lane_valid_o,
  output logic [NUM_CDB-1:0][PTR_W-1:0] lane_idx_o,
  output logic [PTR_W-1:0]              last_idx_o
);

  always_comb begin
    int n;
    int j;
    grant_o      = '0;
    lane_valid_o = '0;
    lane_idx_o   = '0;
    last_idx_o   = rr_ptr_i;
    n            = 0;
    j            = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Rotated index without a modulo operator (NUM_REQ need not be 2^n)
      j = int'(rr_ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid_i[j] && n < NUM_CDB) begin
        grant_o[j]      = 1'b1;
        lane_valid_o[n] = 1'b1;
        lane_idx_o[n]   = PTR_W'(j);
        last_idx_o      = PTR_W'(j);
        n               = n + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: shares NUM_CDB registered broadcast lanes between the ALU RS,
// branch RS and LSQ with round-robin fairness, flush kill and conflict count.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int NUM_CDB = CDB_NUM_CDB,
  parameter int width   = CDB_WIDTH,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ-1:0][width-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_CDB-1:0]              cdb_valid,
  output logic [NUM_CDB-1:0][TAG_W-1:0]   cdb_tag,
  output logic [NUM_CDB-1:0][width-1:0]   cdb_data,
  output logic [NUM_CDB-1:0][1:0]         cdb_src,
  output logic [31:0]                     conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [31:0]                   conflict_q, conflict_d;
  cdb_t                          cdb_q [NUM_CDB];
  cdb_t                          cdb_d [NUM_CDB];

  logic [NUM_REQ-1:0]            grant;
  logic [NUM_CDB-1:0]            lane_valid;
  logic [NUM_CDB-1:0][PTR_W-1:0] lane_idx;
  logic [PTR_W-1:0]              last_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .NUM_CDB (NUM_CDB),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_valid_i  (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .lane_valid_o (lane_valid),
    .lane_idx_o   (lane_idx),
    .last_idx_o   (last_idx)
  );

  // A flushed or reset cycle consumes nothing, so requesters keep holding.
  assign req_ready = (flush || rst) ? '0 : grant;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    conflict_d = conflict_q;
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_d[k] = '0;
      if (lane_valid[k] && !flush) begin
        cdb_d[k].valid = 1'b1;
        cdb_d[k].tag   = req_tag[lane_idx[k]];
        cdb_d[k].data  = req_data[lane_idx[k]];
        cdb_d[k].src   = 2'(lane_idx[k]);
      end
    end
    if (!flush) begin
      if (|grant)
        rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      if ($countones(req_valid) > NUM_CDB && conflict_q != 32'hFFFF_FFFF)
        conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      conflict_q <= '0;
      for (int k = 0; k < NUM_CDB; k++) cdb_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      conflict_q <= conflict_d;
      for (int k = 0; k < NUM_CDB; k++) cdb_q[k] <= cdb_d[k];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_lane
      assign cdb_valid[gi] = cdb_q[gi].valid;
      assign cdb_tag[gi]   = cdb_q[gi].tag;
      assign cdb_data[gi]  = cdb_q[gi].data;
      assign cdb_src[gi]   = cdb_q[gi].src;
    end
  endgenerate

  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a queue-based
// round-robin reference model and a broadcast scoreboard.
module tb_cdb_arbiter;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [2:0]        req_valid;
  logic [2:0][2:0]   req_tag;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic [1:0]        cdb_valid;
  logic [1:0][2:0]   cdb_tag;
  logic [1:0][31:0]  cdb_data;
  logic [1:0][1:0]   cdb_src;
  logic [31:0]       conflict_cnt;

  int          n_checks;
  int          n_errors;
  int          m_ptr;
  logic [31:0] m_cnt;
  logic [36:0] sb [$];
  int          serial;
  logic [2:0]  hold;
  logic [2:0]  got;

  cdb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: drive at the falling edge, check grants, let one rising
  // edge pass, then check the broadcast lanes at the next falling edge.
  task automatic step(input logic [2:0] v, input logic fl, output logic [2:0] granted);
    int          order [$];
    logic [1:0]  e_valid;
    logic [2:0]  e_tag  [2];
    logic [31:0] e_data [2];
    logic [1:0]  e_src  [2];
    int          found;
    req_valid = v;
    flush     = fl;
    #1;
    granted = '0;
    if (!fl) begin
      for (int i = 0; i < 3; i++) begin
        int j;
        j = (m_ptr + i) % 3;
        if (v[j] && order.size() < 2) order.push_back(j);
      end
    end
    foreach (order[n]) granted[order[n]] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(granted));
    e_valid = '0;
    for (int k = 0; k < 2; k++) begin
      e_tag[k] = '0; e_data[k] = '0; e_src[k] = '0;
      if (k < order.size()) begin
        e_valid[k] = 1'b1;
        e_tag[k]   = req_tag[order[k]];
        e_data[k]  = req_data[order[k]];
        e_src[k]   = 2'(order[k]);
        sb.push_back({e_src[k], e_tag[k], e_data[k]});
      end
    end
    @(posedge clk);
    if (!fl) begin
      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % 3;
      if ((int'(v[0]) + int'(v[1]) + int'(v[2])) > 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
    check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("cdb_tag%0d", k), 64'(cdb_tag[k]), 64'(e_tag[k]));
      check($sformatf("cdb_data%0d", k), 64'(cdb_data[k]), 64'(e_data[k]));
      check($sformatf("cdb_src%0d", k), 64'(cdb_src[k]), 64'(e_src[k]));
      if (cdb_valid[k]) begin
        found = 0;
        foreach (sb[n]) begin
          if (found == 0 && sb[n] == {cdb_src[k], cdb_tag[k], cdb_data[k]}) begin
            sb.delete(n);
            found = 1;
          end
        end
        check($sformatf("sb_hit%0d", k), 64'(found), 64'd1);
      end
    end
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    check("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    $display("txn v=%b flush=%b ready=%b cdb_valid=%b ptr=%0d cnt=%0h",
             v, fl, granted, cdb_valid, m_ptr, conflict_cnt);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_ptr     = 0;
    m_cnt     = '0;
    serial    = 1;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    hold      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    step(3'b000, 1'b0, got);

    // All three requesting for three cycles: 0,1 then 2,0 then 1,2
    req_tag[0] = 3'd1; req_data[0] = 32'h1111_0000;
    req_tag[1] = 3'd2; req_data[1] = 32'h2222_0000;
    req_tag[2] = 3'd3; req_data[2] = 32'h3333_0000;
    repeat (3) step(3'b111, 1'b0, got);
    check("conflict_after3", 64'(conflict_cnt), 64'd3);

    // Single requester with wrap-around of the pointer
    req_tag[2] = 3'd5; req_data[2] = 32'hDEAD_BEEF;
    step(3'b100, 1'b0, got);
    check("single_ptr_wrap", 64'(dut.rr_ptr_q), 64'd0);

    // Flush kills the request; retry afterwards grants both
    step(3'b011, 1'b1, got);
    step(3'b011, 1'b0, got);

    // Asynchronous reset between edges while both lanes are busy
    step(3'b111, 1'b0, got);
    check("pre_rst_valid", 64'(cdb_valid), 64'b11);
    sb.delete();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'd0);
    check("arst_tag", 64'(cdb_tag), 64'd0);
    check("arst_data", 64'(cdb_data), 64'd0);
    check("arst_src", 64'(cdb_src), 64'd0);
    check("arst_cnt", 64'(conflict_cnt), 64'd0);
    check("arst_ptr", 64'(dut.rr_ptr_q), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    req_valid = '0;

    // Random requesters holding payloads until granted
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!hold[i] && $urandom_range(1, 0) == 1) begin
          hold[i]     = 1'b1;
          req_tag[i]  = 3'($urandom);
          req_data[i] = 32'(serial);
          serial++;
        end
      end
      step(hold, ($urandom_range(9, 0) == 0), got);
      hold = hold & ~got;
    end
    step(3'b000, 1'b0, got);
    check("sb_empty", 64'(sb.size()), 64'd0);

    // Saturation of the conflict counter
    force dut.conflict_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_q;
    m_cnt = 32'hFFFF_FFFE;
    repeat (3) step(3'b111, 1'b0, got);
    check("sat_cnt", 64'(conflict_cnt), 64'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_CDB common-data-bus broadcast slots between the execution-side requesters: ALU reservation station (index 0), branch reservation station (index 1) and load/store queue (index 2).
- Each granted result (ROB tag plus data) is driven onto one CDB lane, registered, for the ROB and all reservation stations to snoop.
- Round-robin fairness prevents any station from starving.
- A mispredict flush kills in-flight and requested broadcasts.

Parameters:
- NUM_REQ, 3, number of requesters (0 = acu, 1 = br, 2 = lsq).
- NUM_CDB, 2, number of broadcast lanes per cycle.
- width, 32, result data width.
- TAG_W, 3, ROB tag width (ROB size 8).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- flush, input, 1, mispredict flush; kills all broadcasts.
- req_valid, input, [NUM_REQ], requester has a result.
- req_tag, input, [NUM_REQ][TAG_W], ROB tag of the result.
- req_data, input, [NUM_REQ][width], result value.
- req_ready, output, [NUM_REQ], grant; the result is consumed this cycle.
- cdb_valid, output, [NUM_CDB], lane carries a result.
- cdb_tag, output, [NUM_CDB][TAG_W], broadcast ROB tag.
- cdb_data, output, [NUM_CDB][width], broadcast data.
- cdb_src, output, [NUM_CDB][2], requester index that owns each lane.
- conflict_cnt, output, 32, cycles where valid requests exceeded NUM_CDB; saturating.

Behaviour:
- Reset (async, immediate) sets:
  - cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt all to 0.
  - RR pointer rr_ptr to 0.
  - req_ready to 0 while rst is high.
  - Reset mid-operation drops every pending grant; requesters must re-present.
- Handshake:
  - A requester holds req_valid, req_tag and req_data stable until it sees req_ready=1 at a rising edge.
  - req_ready is combinational from the current-cycle req_valid, rr_ptr and flush.
  - req_ready is never 1 when req_valid is 0.
- Arbitration (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first min(NUM_CDB, popcount(req_valid)) valid requesters.
  - The k-th granted requester (k = 0..NUM_CDB-1) maps to lane k.
- Latency:
  - A grant at edge N appears on cdb_* after edge N.
  - Each lane holds for exactly one cycle. Ungranted lanes have cdb_valid=0 with tag, data and src cleared to 0.
- Pointer update at each edge:
  - If at least one grant was issued, rr_ptr becomes (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap-around: last granted = NUM_REQ-1 gives rr_ptr = 0.
- Flush (cycle with flush=1):
  - req_ready is forced to all 0.
  - At the edge, cdb_valid clears to 0. Broadcasts already registered before the flush edge still complete in the flush cycle.
  - rr_ptr is unchanged; conflict_cnt does not increment.
- conflict_cnt:
  - Increments at an edge when popcount(req_valid) > NUM_CDB and flush=0.
  - Saturates at 32'hFFFF_FFFF.
- All requesters idle: no grants, lanes invalid, pointer holds.
- Exactly NUM_CDB valid requests: all granted, no conflict count.
- Tag uniqueness is not checked here; the ROB guarantees it.

Decomposition:
- Shared package rv32i_types gets:
  - cdb_t struct: valid, tag[TAG_W-1:0], data[width-1:0], src[1:0].
  - Constants REQ_ACU=0, REQ_BR=1, REQ_LSQ=2.
  - Output lanes become cdb_t cdb[NUM_CDB].
- One sub-module, rr_pick: purely combinational. Inputs are req_valid, rr_ptr and NUM_CDB; outputs are the grant vector, per-lane requester index and last granted index.
- cdb_arbiter holds the registers (rr_ptr, lane registers, conflict_cnt), flush gating and the saturating counter.

Test Plan:
- Reset then idle, rr_ptr=0. Hold req_valid=3'b111 for 3 cycles:
  - cycle0 grants 0,1 (lanes 0,1);
  - cycle1 grants 2,0;
  - cycle2 grants 1,2;
  - conflict_cnt=3 after cycle2.
- Single requester: req_valid=3'b100, tag=5, data=32'hDEAD_BEEF. req_ready[2]=1 the same cycle; next cycle cdb_valid=2'b01, cdb_tag[0]=5, cdb_data[0]=32'hDEAD_BEEF, cdb_src[0]=2; rr_ptr=0 (wrap-around).
- Flush: req_valid=3'b011 with flush=1. req_ready=0; after the edge cdb_valid=0; rr_ptr unchanged; a retry the next cycle with flush=0 grants both.
- Async reset mid-broadcast: assert rst between edges while cdb_valid=2'b11. Outputs clear to 0 immediately without waiting for clk; rr_ptr=0; conflict_cnt=0.
- Hold stability: requester 1 is ungranted for 1 cycle with a stable payload and is granted the next cycle. Check the ROB tag is broadcast exactly once, with no duplicate or dropped broadcast over 100 random-request cycles (scoreboard).
- Saturation: force conflict_cnt near max (32'hFFFF_FFFE) and apply 3 conflict cycles. conflict_cnt stays at 32'hFFFF_FFFF.
